display_frame_sequencer: RTL
============================

# display_frame_sequencer

Upstream driver for the desk clock's serial 7-segment display chain. On a `start` request it snapshots a BCD digit vector and decimal-point mask. It decodes each digit to segment form, then shifts all digits out bit-serially with a generated serial clock. It finishes the frame with a latch strobe to the external shift-register drivers, so the display only ever updates with a complete, untorn frame.

## Interface
- `NUM_DIGITS`, 4: digits per frame, ≥1.
- `CLK_DIV`, 2: `clk` cycles per serial-clock half-period, ≥1.
- `INVERT`, 0: 1 inverts all 8 output bits (common-anode parts).

- `clk`, input, 1: system clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `ena`, input, 1: clock enable; when low, all state and outputs hold.
- `start`, input, 1: frame request, sampled only in IDLE.
- `digits_bcd`, input, 4·NUM_DIGITS: digit i is `[4i+3:4i]`.
- `dp_mask`, input, NUM_DIGITS: bit i lights the DP of digit i.
- `busy`, output, 1: frame in progress.
- `done`, output, 1: one-cycle pulse at frame end.
- `serial_data`, output, 1: segment bit to the chain.
- `serial_clk`, output, 1: shift clock; the chain samples on its rising edge.
- `serial_latch`, output, 1: storage-register strobe.

## Operation
- **Segment byte:** bit0 = a … bit6 = g, bit7 = dp; 1 = lit before INVERT.
- **Decode:** 0–9 use standard glyphs (0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F). Codes 10–15 decode to blank (0x00); DP is still honoured.
- **FSM states:** IDLE → LOAD → SHIFT_LO ⇄ SHIFT_HI → (LOAD | LATCH) → DONE → IDLE.
- **IDLE:** when `start` is seen, register `digits_bcd` and `dp_mask`, set digit index to NUM_DIGITS−1, go to LOAD.
- **LOAD:** for 1 cycle, put the decoded byte of the current digit into an 8-bit shift register; bit count = 0.
- **SHIFT_LO:** `serial_clk` = 0 and `serial_data` = shreg[0] for CLK_DIV cycles.
- **SHIFT_HI:** `serial_clk` = 1 for CLK_DIV cycles; on exit, shift right with 0 fill and increment bit count.
- **After bit 7:** go to LOAD with the next lower digit, or to LATCH after digit 0.
- **Shift order:** digit NUM_DIGITS−1 goes first; LSB (segment a) first within each digit; dp last.
- **LATCH:** `serial_latch` = 1, `serial_clk` = 0, `serial_data` = 0 for CLK_DIV cycles.
- **DONE:** `done` = 1 and `busy` = 0 for 1 cycle, then IDLE.
- **`start` outside IDLE** is ignored (not queued). Snapshot inputs do not change mid-frame.
- **Width rules:** digit index is clog2(NUM_DIGITS) bits (min 1); bit count 3 bits; divider counter clog2(CLK_DIV) bits (min 1), terminal at CLK_DIV−1.

## Timing
- **Reset values:** IDLE; `busy`, `done`, `serial_data`, `serial_clk`, `serial_latch` all 0; all counters and registers 0.
- **Reset mid-frame:** outputs go to reset values immediately. No latch pulse is issued, so the display keeps its previous frame.
- **`busy`:** a `start` sampled at edge k gives `busy` = 1 from cycle k+1 through cycle k+F.
  - F = NUM_DIGITS·(1 + 16·CLK_DIV) + CLK_DIV; defaults give F = 134.
- **`done`:** high in cycle k+F+1. IDLE can accept a new `start` in cycle k+F+2.
- **Data timing:** `serial_data` changes only while `serial_clk` = 0 (at SHIFT_LO entry). It is stable for ≥CLK_DIV cycles before and during each high phase.
- **Outputs:** all registered, no combinational path from inputs.
- **`ena` low:** freezes the divider, FSM and outputs, and extends every count by the frozen cycles.

## Structure
- Shared package `display_pkg` holds the segment-byte bit positions, the 16-entry BCD→segment constant table, the blank code, and the FSM state enum.
- Sub-module `bcd_to_seven_seg`: combinational 4-bit BCD + dp → 8-bit segment byte with INVERT parameter. It is instantiated once, on the muxed current digit.
- Everything else (FSM, divider, shift register, counters) stays in this module.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-SHIFT_HI → all outputs 0 at once, no `serial_latch` pulse; after release, `busy` = 0 and IDLE.
- **Basic frame:** defaults, `digits_bcd` = 0x1234, `dp_mask` = 0b0100, `start` at k.
  - 32 rising `serial_clk` edges sample bytes 0x06, 0xDB, 0x4F, 0x66, LSB first.
  - `serial_latch` high for 2 cycles; `done` at k+135.
- **Blanking:** digit = 0xA, dp = 1 → byte 0x80. With INVERT = 1, digit 8, dp = 0 → 0x80.
- **Busy/start interplay:** `start` held high continuously → back-to-back frames, each of 134 busy cycles with one `done` cycle between. Changing `digits_bcd` mid-frame does not alter shifted bits.
- **Enable stall:** `ena` low for 10 cycles during SHIFT_LO → outputs constant, `done` delayed by exactly 10 cycles.
- **Parameter corners:** NUM_DIGITS = 1, CLK_DIV = 1 → F = 18, 8 bits shifted, `serial_clk` toggles every cycle.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the serial 7-segment display path: segment-byte layout,
// BCD glyph table and the frame sequencer state encoding.
package display_pkg;

  localparam int unsigned SEG_DP = 7;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Entry n is the glyph for BCD code n, bit0 = a ... bit6 = g, dp clear.
  localparam logic [15:0][7:0] SEG_TABLE = {
    SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
    8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/bcd_to_seven_seg.sv
// Combinational BCD digit + decimal point to segment byte, optionally inverted
// for common-anode drivers.
module bcd_to_seven_seg
  import display_pkg::*;
#(
  parameter int unsigned INVERT = 0
) (
  input  logic [3:0] bcd_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  logic [7:0] seg;

  always_comb begin
    seg         = SEG_TABLE[bcd_i];
    seg[SEG_DP] = dp_i;
    seg_o       = (INVERT != 0) ? ~seg : seg;
  end

endmodule

// File: rtl/display_frame_sequencer.sv
// Snapshots a BCD frame, shifts it bit-serially to the display chain with a
// generated serial clock, then strobes the latch so the display never tears.
module display_frame_sequencer
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned INVERT     = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic                    busy,
  output logic                    done,
  output logic                    serial_data,
  output logic                    serial_clk,
  output logic                    serial_latch
);

  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [IW-1:0] IDX_TOP  = IW'(NUM_DIGITS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  seq_state_e              state_q, state_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [2:0]              bitcnt_q, bitcnt_d;
  logic [DW-1:0]           div_q, div_d;
  logic [7:0]              shreg_q, shreg_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    sdata_q, sdata_d;
  logic                    sclk_q, sclk_d;
  logic                    slatch_q, slatch_d;

  logic [3:0] cur_bcd;
  logic       cur_dp;
  logic [7:0] cur_seg;
  logic       div_last;

  always_comb begin
    cur_bcd = '0;
    cur_dp  = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_bcd = digits_q[4*i +: 4];
        cur_dp  = dp_q[i];
      end
    end
  end

  bcd_to_seven_seg #(.INVERT(INVERT)) u_dec (
    .bcd_i (cur_bcd),
    .dp_i  (cur_dp),
    .seg_o (cur_seg)
  );

  assign div_last = (div_q == DIV_LAST);

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    dp_d     = dp_q;
    idx_d    = idx_q;
    bitcnt_d = bitcnt_q;
    div_d    = div_q;
    shreg_d  = shreg_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          digits_d = digits_bcd;
          dp_d     = dp_mask;
          idx_d    = IDX_TOP;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        shreg_d  = cur_seg;
        bitcnt_d = '0;
        div_d    = '0;
        state_d  = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        if (div_last) begin
          div_d   = '0;
          state_d = ST_SHIFT_HI;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      ST_SHIFT_HI: begin
        if (div_last) begin
          div_d    = '0;
          shreg_d  = {1'b0, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q != 3'd7) begin
            state_d = ST_SHIFT_LO;
          end else if (idx_q == '0) begin
            state_d = ST_LATCH;
          end else begin
            idx_d   = idx_q - IW'(1);
            state_d = ST_LOAD;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      ST_LATCH: begin
        if (div_last) begin
          div_d   = '0;
          state_d = ST_DONE;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state
  // they describe; serial_data only moves when entering or staying in SHIFT_LO.
  always_comb begin
    busy_d   = (state_d == ST_LOAD) || (state_d == ST_SHIFT_LO) ||
               (state_d == ST_SHIFT_HI) || (state_d == ST_LATCH);
    done_d   = (state_d == ST_DONE);
    sclk_d   = (state_d == ST_SHIFT_HI);
    slatch_d = (state_d == ST_LATCH);
    unique case (state_d)
      ST_SHIFT_LO:         sdata_d = shreg_d[0];
      ST_SHIFT_HI, ST_LOAD: sdata_d = sdata_q;
      default:             sdata_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      digits_q <= '0;
      dp_q     <= '0;
      idx_q    <= '0;
      bitcnt_q <= '0;
      div_q    <= '0;
      shreg_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sdata_q  <= 1'b0;
      sclk_q   <= 1'b0;
      slatch_q <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      digits_q <= digits_d;
      dp_q     <= dp_d;
      idx_q    <= idx_d;
      bitcnt_q <= bitcnt_d;
      div_q    <= div_d;
      shreg_q  <= shreg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sdata_q  <= sdata_d;
      sclk_q   <= sclk_d;
      slatch_q <= slatch_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign serial_data  = sdata_q;
  assign serial_clk   = sclk_q;
  assign serial_latch = slatch_q;

endmodule
